// File: rtl/iic_target_if.sv
// Local-side data path of the I2C target: byte delivery, byte request and status.
// The target is the slave end; local logic is the master end.
interface iic_target_if;
  logic [7:0] i_tx_data;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic       o_tx_req;
  logic       o_busy;
  logic       o_rw;

  modport slave (
    input  i_tx_data,
    output o_rx_data, o_rx_valid, o_tx_req, o_busy, o_rw
  );

  modport master (
    output i_tx_data,
    input  o_rx_data, o_rx_valid, o_tx_req, o_busy, o_rw
  );
endinterface

// File: rtl/iic_target.sv
// I2C target with a fixed 7-bit address; ACKs every written byte and serves reads from local logic.
// SCL is input-only; SDA is open drain and only ever changes on a detected SCL falling edge.
module iic_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scl,
  inout  wire         sda,
  iic_target_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic                   scl_prev_q, sda_prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
      scl_prev_q <= scl_sync_q[SYNC_STAGES-1];
      sda_prev_q <= sda_sync_q[SYNC_STAGES-1];
    end
  end

  logic scl_now, sda_now, scl_rise, scl_fall, start_det, stop_det;
  assign scl_now   = scl_sync_q[SYNC_STAGES-1];
  assign sda_now   = sda_sync_q[SYNC_STAGES-1];
  assign scl_rise  = ~scl_prev_q & scl_now;
  assign scl_fall  = scl_prev_q & ~scl_now;
  assign start_det = scl_prev_q & scl_now & sda_prev_q & ~sda_now;
  assign stop_det  = scl_prev_q & scl_now & ~sda_prev_q & sda_now;

  state_t     state_q;
  logic [2:0] bit_cnt_q;
  logic       byte_done_q;
  logic [7:0] rx_shift_q;
  logic [6:0] tx_shift_q;
  logic       ack_q;
  logic       sda_low_q;
  logic [7:0] rx_data_q;
  logic       rx_valid_q, tx_req_q, busy_q, rw_q;

  // byte_done_q marks that bit 0 was sampled; the following SCL fall acts on the byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      bit_cnt_q   <= 3'd7;
      byte_done_q <= 1'b0;
      rx_shift_q  <= 8'h00;
      tx_shift_q  <= 7'h00;
      ack_q       <= 1'b0;
      sda_low_q   <= 1'b0;
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      busy_q      <= 1'b0;
      rw_q        <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      tx_req_q   <= 1'b0;
      if (start_det) begin
        state_q     <= ADDR;
        bit_cnt_q   <= 3'd7;
        byte_done_q <= 1'b0;
        sda_low_q   <= 1'b0;
        busy_q      <= 1'b0;
      end else if (stop_det) begin
        state_q   <= IDLE;
        sda_low_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: ;
          ADDR, WR_DATA: begin
            if (scl_rise) begin
              rx_shift_q <= {rx_shift_q[6:0], sda_now};
              if (bit_cnt_q == 3'd0) byte_done_q <= 1'b1;
              else                   bit_cnt_q   <= bit_cnt_q - 3'd1;
            end else if (scl_fall && byte_done_q) begin
              byte_done_q <= 1'b0;
              if (state_q == WR_DATA) begin
                rx_data_q  <= rx_shift_q;
                rx_valid_q <= 1'b1;
                sda_low_q  <= 1'b1;
                state_q    <= WR_ACK;
              end else if (rx_shift_q[7:1] == TARGET_ADDR) begin
                sda_low_q <= 1'b1;
                rw_q      <= rx_shift_q[0];
                busy_q    <= 1'b1;
                state_q   <= ADDR_ACK;
              end else begin
                state_q <= IDLE;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= 3'd7;
              if (!rw_q) begin
                sda_low_q <= 1'b0;
                state_q   <= WR_DATA;
              end else begin
                tx_shift_q <= bus.i_tx_data[6:0];
                tx_req_q   <= 1'b1;
                sda_low_q  <= ~bus.i_tx_data[7];
                state_q    <= RD_DATA;
              end
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              sda_low_q <= 1'b0;
              bit_cnt_q <= 3'd7;
              state_q   <= WR_DATA;
            end
          end
          RD_DATA: begin
            if (scl_fall) begin
              if (bit_cnt_q == 3'd0) begin
                sda_low_q <= 1'b0;
                state_q   <= RD_ACK;
              end else begin
                bit_cnt_q  <= bit_cnt_q - 3'd1;
                tx_shift_q <= {tx_shift_q[5:0], 1'b0};
                sda_low_q  <= ~tx_shift_q[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              ack_q <= sda_now;
            end else if (scl_fall) begin
              if (!ack_q) begin
                tx_shift_q <= bus.i_tx_data[6:0];
                tx_req_q   <= 1'b1;
                sda_low_q  <= ~bus.i_tx_data[7];
                bit_cnt_q  <= 3'd7;
                state_q    <= RD_DATA;
              end else begin
                sda_low_q <= 1'b0;
                busy_q    <= 1'b0;
                state_q   <= IDLE;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign sda = sda_low_q ? 1'b0 : 1'bz;

  assign bus.o_rx_data  = rx_data_q;
  assign bus.o_rx_valid = rx_valid_q;
  assign bus.o_tx_req   = tx_req_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_rw       = rw_q;

endmodule
